// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: instruction fetch and data requesters share one AXI read port.
// One transaction at a time; round-robin on ties, beat-count checking against arlen.
module axi_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  output logic              i_rvalid,
  output logic              i_rlast,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,

  input  logic              d_arvalid,
  output logic              d_arready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,

  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  input  logic [DATA_W-1:0] m_axi_rdata,
  output logic              m_axi_rready,

  output logic              grant_d,
  output logic              busy,
  output logic              burst_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic              last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt;
  logic              late_seen;

  logic              req_any;
  logic              pick_d;
  logic              grant;
  logic              in_data;
  logic              beat;
  logic              early_err;
  logic              late_err;

  // Ties go to whichever requester did not win last time.
  always_comb begin
    req_any = i_arvalid | d_arvalid;
    pick_d  = 1'b0;
    if (i_arvalid && d_arvalid) begin
      pick_d = ~last_d;
    end else if (d_arvalid) begin
      pick_d = 1'b1;
    end
    grant = (state == IDLE) && req_any && reset;
  end

  assign i_arready = grant & ~pick_d;
  assign d_arready = grant &  pick_d;

  assign in_data   = (state == DATA);
  assign beat      = in_data & m_axi_rvalid & m_axi_rready;
  // beat_cnt holds beats already accepted, so the final beat arrives with beat_cnt == len_q.
  assign early_err = beat &  m_axi_rlast & (beat_cnt < len_q);
  assign late_err  = beat & ~m_axi_rlast & (beat_cnt == len_q) & ~late_seen;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ADDR;
      ADDR:    if (m_axi_arready) state_nxt = DATA;
      DATA:    if (beat && m_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      grant_d   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      late_seen <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_err <= early_err | late_err;
      if (grant) begin
        grant_d <= pick_d;
        addr_q  <= pick_d ? d_araddr  : i_araddr;
        len_q   <= pick_d ? d_arlen   : i_arlen;
        size_q  <= pick_d ? d_arsize  : i_arsize;
        burst_q <= pick_d ? d_arburst : i_arburst;
      end
      if (state == ADDR && m_axi_arready) begin
        beat_cnt  <= '0;
        late_seen <= 1'b0;
      end else if (beat) begin
        if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
        if (late_err) late_seen <= 1'b1;
        if (m_axi_rlast) begin
          last_d  <= grant_d;
          grant_d <= 1'b0;
        end
      end
    end
  end

  assign busy          = (state != IDLE);
  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;

  // Read data is routed only to the owner; the other side sees valid/last held low.
  assign m_axi_rready  = in_data & (grant_d ? d_rready : i_rready);
  assign i_rvalid      = in_data & ~grant_d & m_axi_rvalid;
  assign i_rlast       = in_data & ~grant_d & m_axi_rlast;
  assign i_rdata       = m_axi_rdata;
  assign d_rvalid      = in_data &  grant_d & m_axi_rvalid;
  assign d_rlast       = in_data &  grant_d & m_axi_rlast;
  assign d_rdata       = m_axi_rdata;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized scoreboard bench for axi_read_arbiter with a transaction-level arbitration model
// and a reactive AXI slave; directed bursts cover beat-count errors and reset in ADDR.
module tb_axi_read_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic reset;
  logic i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [ADDR_W-1:0] i_araddr;
  logic [7:0] i_arlen;
  logic [2:0] i_arsize;
  logic [1:0] i_arburst;
  logic [DATA_W-1:0] i_rdata;
  logic d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [ADDR_W-1:0] d_araddr;
  logic [7:0] d_arlen;
  logic [2:0] d_arsize;
  logic [1:0] d_arburst;
  logic [DATA_W-1:0] d_rdata;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic [DATA_W-1:0] m_axi_rdata;
  logic grant_d, busy, burst_err;

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .i_rdata(i_rdata), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_arburst(d_arburst), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
    .d_rdata(d_rdata), .d_rready(d_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready),
    .grant_d(grant_d), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          cyc;
  } ar_t;
  typedef struct {
    logic        last;
    logic [63:0] data;
  } beat_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int err_mode = 0;   // 0 normal, 1 rlast one beat early, 2 rlast two beats late
  int force_dly = -1;

  ar_t   exp_ar[$];
  beat_t q_i[$];
  beat_t q_d[$];
  bit    err_q[$];    // expected busy level while burst_err is high

  bit port_free = 1'b1;
  bit last_d_m  = 1'b1;
  bit owner_d   = 1'b0;
  int s_phase   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] a, input int b);
    return a ^ (64'(b) << 40) ^ 64'h00A5_5A00_0000_1234;
  endfunction

  function automatic int last_index(input int len, input int mode);
    if (mode == 1) return len - 1;
    if (mode == 2) return len + 2;
    return len;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Requester read-ready: random backpressure on both sides.
  initial begin
    i_rready = 1'b0;
    d_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_rready = ($urandom_range(0, 3) != 0);
      d_rready = ($urandom_range(0, 2) != 0);
    end
  end

  // Reference model: one transaction at a time, round-robin on ties, free again after rlast.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      port_free = 1'b1;
      last_d_m  = 1'b1;
      exp_ar.delete();
      q_i.delete();
      q_d.delete();
      err_q.delete();
    end else begin
      if (port_free && (i_arvalid || d_arvalid)) begin
        ar_t e;
        int nb;
        bit win_d;
        win_d = (i_arvalid && d_arvalid) ? !last_d_m : d_arvalid;
        chk("i_arready_grant", i_arready, !win_d);
        chk("d_arready_grant", d_arready, win_d);
        owner_d   = win_d;
        port_free = 1'b0;
        e.addr  = win_d ? d_araddr  : i_araddr;
        e.len   = win_d ? d_arlen   : i_arlen;
        e.size  = win_d ? d_arsize  : i_arsize;
        e.burst = win_d ? d_arburst : i_arburst;
        e.cyc   = cyc;
        exp_ar.push_back(e);
        nb = last_index(int'(e.len), err_mode) + 1;
        for (int b = 0; b < nb; b++) begin
          beat_t bt;
          bt.last = (b == nb - 1);
          bt.data = beat_data(e.addr, b);
          if (win_d) q_d.push_back(bt); else q_i.push_back(bt);
        end
        if (err_mode == 1) err_q.push_back(1'b0);
        if (err_mode == 2) err_q.push_back(1'b1);
      end else if (!port_free && (i_arvalid || d_arvalid)) begin
        chk("arready_while_busy", {i_arready, d_arready}, 2'b00);
      end
      if (!port_free && m_axi_rvalid) begin
        chk("m_rready_route", m_axi_rready, owner_d ? d_rready : i_rready);
        if (m_axi_rready && m_axi_rlast) begin
          port_free = 1'b1;
          last_d_m  = owner_d;
        end
      end
    end
  end

  // Requester-side monitor: every forwarded beat must match the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset && i_rvalid && i_rready) begin
      chk("d_rvalid_quiet", d_rvalid, 1'b0);
      chk("grant_d_on_i", grant_d, 1'b0);
      if (q_i.size() == 0) fail_now("i_beat_unexpected");
      else begin
        beat_t bt;
        bt = q_i.pop_front();
        chk("i_rdata", i_rdata, bt.data);
        chk("i_rlast", i_rlast, bt.last);
      end
    end
    if (reset && d_rvalid && d_rready) begin
      chk("i_rvalid_quiet", i_rvalid, 1'b0);
      chk("grant_d_on_d", grant_d, 1'b1);
      if (q_d.size() == 0) fail_now("d_beat_unexpected");
      else begin
        beat_t bt;
        bt = q_d.pop_front();
        chk("d_rdata", d_rdata, bt.data);
        chk("d_rlast", d_rlast, bt.last);
      end
    end
  end

  // burst_err monitor: each high cycle must match one expected error.
  initial forever begin
    @(negedge clk);
    if (reset && burst_err) begin
      if (err_q.size() == 0) fail_now("burst_err_unexpected");
      else chk("busy_at_burst_err", busy, err_q.pop_front());
    end
  end

  // Reactive AXI slave.
  initial begin
    bit ar_hs, r_hs, ar_seen;
    int dly, beat, last_idx;
    logic [63:0] s_addr;
    int s_len;
    ar_seen = 1'b0; dly = 0; beat = 0; last_idx = 0; s_addr = '0; s_len = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (reset && m_axi_arvalid) begin
        if (!ar_seen) begin
          ar_seen = 1'b1;
          if (exp_ar.size() == 0) fail_now("m_arvalid_unexpected");
          else begin
            ar_t e;
            e = exp_ar.pop_front();
            chk("m_araddr", m_axi_araddr, e.addr);
            chk("m_arlen", m_axi_arlen, e.len);
            chk("m_arsize", m_axi_arsize, e.size);
            chk("m_arburst", m_axi_arburst, e.burst);
            chk("ar_latency", cyc, e.cyc + 1);
            s_addr = e.addr;
            s_len  = int'(e.len);
          end
          dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
          force_dly = -1;
        end else begin
          chk("m_araddr_hold", m_axi_araddr, s_addr);
        end
      end
      @(posedge clk); #1;
      if (!reset) begin
        s_phase = 0; ar_seen = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else if (s_phase == 0) begin
        if (ar_hs) begin
          m_axi_arready = 1'b0;
          ar_seen  = 1'b0;
          s_phase  = 1;
          beat     = 0;
          last_idx = last_index(s_len, err_mode);
        end else if (ar_seen) begin
          if (dly == 0) m_axi_arready = 1'b1;
          else dly--;
        end
      end else begin
        if (r_hs) begin
          m_axi_rvalid = 1'b0;
          if (beat == last_idx) begin
            s_phase = 0;
            m_axi_rlast = 1'b0;
          end
          beat++;
        end
        if (s_phase == 1 && !m_axi_rvalid && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = beat_data(s_addr, beat);
          m_axi_rlast  = (beat == last_idx);
        end
      end
    end
  end

  task automatic req(input bit is_d, input logic [63:0] a, input logic [7:0] l, input int gap);
    int n;
    logic [2:0] sz;
    logic [1:0] bu;
    sz = 3'($urandom_range(0, 3));
    bu = 2'($urandom_range(0, 2));
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    if (is_d) begin
      d_arvalid = 1'b1; d_araddr = a; d_arlen = l; d_arsize = sz; d_arburst = bu;
    end else begin
      i_arvalid = 1'b1; i_araddr = a; i_arlen = l; i_arsize = sz; i_arburst = bu;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_arready : i_arready) && n < 4000);
    if (n >= 4000) fail_now(is_d ? "d_arready_timeout" : "i_arready_timeout");
    @(posedge clk); #1;
    if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
  endtask

  task automatic run_random(input bit is_d);
    for (int k = 0; k < 14; k++) begin
      logic [63:0] a;
      a = {32'h0, $urandom} & ~64'h7;
      req(is_d, a, 8'($urandom_range(0, 7)), (k == 0) ? 0 : int'($urandom_range(0, 4)));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port_free && s_phase == 0 && q_i.size() == 0 && q_d.size() == 0 &&
                 err_q.size() == 0 && exp_ar.size() == 0) && n < 5000);
    if (n >= 5000) fail_now("drain_timeout");
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_grant_d", grant_d, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    i_arvalid = 1'b1; i_araddr = 64'h40; i_arlen = 8'd2; i_arsize = 3'd3; i_arburst = 2'd1;
    d_arvalid = 1'b1; d_araddr = 64'h80; d_arlen = 8'd2; d_arsize = 3'd3; d_arburst = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_arready", i_arready, 1'b0);
    chk("rst_d_arready", d_arready, 1'b0);
    chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_m_rready", m_axi_rready, 1'b0);
    chk("rst_rvalid", {i_rvalid, d_rvalid, i_rlast, d_rlast}, 4'b0);
    chk("rst_grant_d", grant_d, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_burst_err", burst_err, 1'b0);
    chk("rst_m_araddr", m_axi_araddr, 64'h0);
    i_arvalid = 1'b0;
    d_arvalid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;

    // Both requesters start in the same cycle, so the first grant is a tie.
    fork
      run_random(1'b0);
      run_random(1'b1);
    join
    wait_idle();

    // Single instruction burst with a slow arready.
    force_dly = 2;
    req(1'b0, 64'h1000, 8'd7, 0);
    wait_idle();

    // rlast one beat early on a len-3 burst.
    err_mode = 1;
    req(1'b1, 64'h4000, 8'd3, 0);
    wait_idle();

    // rlast missing at the expected beat on a len-1 burst.
    err_mode = 2;
    req(1'b0, 64'h5000, 8'd1, 0);
    wait_idle();
    err_mode = 0;

    // Reset while in ADDR with a data request pending.
    force_dly = 20;
    fork
      req(1'b0, 64'h2000, 8'd2, 0);
      req(1'b1, 64'h3000, 8'd2, 3);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_axi_arvalid && n < 100);
        if (n >= 100) fail_now("addr_phase_timeout");
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_m_arvalid", m_axi_arvalid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_d_arready", d_arready, 1'b0);
        chk("async_rst_grant_d", grant_d, 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
      end
    join
    wait_idle();

    chk("leftover_i_beats", q_i.size(), 0);
    chk("leftover_d_beats", q_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
